// File: rtl/imem_arbiter_if.sv
// Bundles the fetch, loader and RAM-side signals of the instruction-memory arbiter.
// The arbiter uses the slave modport; the requesters, RAM and bench use the master modport.
interface imem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;

    logic              l_req;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction RAM between the fetch stage (reads) and the program loader (writes).
// Loader has strict priority in load_mode, round-robin otherwise; a wait counter bounds fetch starvation.
module imem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_mode,
    imem_arbiter_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        GNT_FETCH  = 1'b0,
        GNT_LOADER = 1'b1
    } gnt_side_e;

    gnt_side_e         last_gnt_q, last_gnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              f_rvalid_q, f_rvalid_d;
    logic [31:0]       f_rdata_q, f_rdata_d;

    logic              f_gnt;
    logic              l_gnt;
    logic              starving;

    assign starving = (wait_cnt_q == WAIT_W'(MAX_WAIT));

    // Grants are suppressed while reset is held so nothing touches the RAM during reset.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst_n) begin
            if (bus.f_req && !bus.l_req) begin
                f_gnt = 1'b1;
            end else if (bus.l_req && !bus.f_req) begin
                l_gnt = 1'b1;
            end else if (bus.f_req && bus.l_req) begin
                if (starving) begin
                    f_gnt = 1'b1;
                end else if (load_mode) begin
                    l_gnt = 1'b1;
                end else if (last_gnt_q == GNT_LOADER) begin
                    f_gnt = 1'b1;
                end else begin
                    l_gnt = 1'b1;
                end
            end
        end
    end

    assign bus.f_gnt = f_gnt;
    assign bus.l_gnt = l_gnt;

    always_comb begin
        bus.mem_en    = f_gnt | l_gnt;
        bus.mem_we    = l_gnt;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (f_gnt) begin
            bus.mem_addr = bus.f_addr[ADDR_W+1:2];
        end else if (l_gnt) begin
            bus.mem_addr  = bus.l_addr[ADDR_W+1:2];
            bus.mem_wdata = bus.l_wdata;
        end
    end

    // A read in flight is discarded as soon as reset is asserted, even before the reset edge.
    assign bus.f_rvalid = f_rvalid_q & rst_n;
    assign bus.f_rdata  = bus.f_rvalid ? bus.mem_rdata : f_rdata_q;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (f_gnt) begin
            last_gnt_d = GNT_FETCH;
        end else if (l_gnt) begin
            last_gnt_d = GNT_LOADER;
        end

        wait_cnt_d = '0;
        if (bus.f_req && !f_gnt) begin
            wait_cnt_d = starving ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        f_rvalid_d = f_gnt;
        f_rdata_d  = bus.f_rvalid ? bus.mem_rdata : f_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= GNT_LOADER;
            wait_cnt_q <= '0;
            f_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
            f_rvalid_q <= f_rvalid_d;
            f_rdata_q  <= f_rdata_d;
        end
    end

    // Only the word-address bits reach the RAM; the rest of each byte address is dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.f_addr[31:ADDR_W+2], bus.f_addr[1:0],
                                bus.l_addr[31:ADDR_W+2], bus.l_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter: a reference model predicts grants, RAM drive
// and fetch return data; a monitor process checks every returned fetch against a queue.
module tb_imem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_mode = 1'b0;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    imem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_mode(load_mode),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] ram_init(input int idx);
        return (idx * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // RAM environment: registered read, write-first across cycles
    logic [31:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = ram_init(i);
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
                else            bus.mem_rdata     <= ram[bus.mem_addr];
            end
        end
    end

    // Reference model state
    int          m_last = 2;   // 1 = fetch won last, 2 = loader won last
    int          m_denied = 0; // consecutive cycles fetch was refused
    logic [31:0] m_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] last_data = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] byte_addr);
        return int'((byte_addr >> 2) % DEPTH);
    endfunction

    task automatic applyStimulus(input logic rn, input logic lm,
                                 input logic fr, input logic [31:0] fa,
                                 input logic lr, input logic [31:0] la, input logic [31:0] lw);
        @(posedge clk);
        #2;
        rst_n       = rn;
        load_mode   = lm;
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.l_req   = lr;
        bus.l_addr  = la;
        bus.l_wdata = lw;
    endtask

    // Predicts this cycle's winner from the arbitration rules, compares, then advances the model
    task automatic checkOutput(output int w);
        int wa;
        #2;
        w = 0;
        if (rst_n) begin
            if (bus.f_req && !bus.l_req)       w = 1;
            else if (bus.l_req && !bus.f_req)  w = 2;
            else if (bus.f_req && bus.l_req) begin
                if (m_denied >= MAX_WAIT)      w = 1;
                else if (load_mode)            w = 2;
                else                           w = (m_last == 2) ? 1 : 2;
            end
        end
        wa = (w == 1) ? word_of(bus.f_addr) : (w == 2) ? word_of(bus.l_addr) : 0;
        check("f_gnt",     bus.f_gnt,  (w == 1));
        check("l_gnt",     bus.l_gnt,  (w == 2));
        check("mem_en",    bus.mem_en, (w != 0));
        check("mem_we",    bus.mem_we, (w == 2));
        check("mem_addr",  bus.mem_addr, wa);
        check("mem_wdata", bus.mem_wdata, (w == 2) ? bus.l_wdata : 32'h0);

        if (!rst_n) begin
            m_last   = 2;
            m_denied = 0;
        end else begin
            if (w != 0) m_last = w;
            if (bus.f_req && w != 1) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
            else                     m_denied = 0;
            if (w == 2) m_mem[wa] = bus.l_wdata;
            if (w == 1) exp_q.push_back(m_mem[wa]);
        end
    endtask

    // Monitor: in every cycle a returned fetch must match the oldest expected word
    initial begin
        logic [31:0] d;
        forever begin
            @(posedge clk);
            #3;
            if (!rst_n) begin
                exp_q.delete();
                check("rvalid_in_reset", bus.f_rvalid, 1'b0);
                last_data = 32'h0;
            end else if (exp_q.size() > 0) begin
                d = exp_q.pop_front();
                check("rvalid", bus.f_rvalid, 1'b1);
                check("rdata", bus.f_rdata, d);
                last_data = d;
            end else begin
                check("rvalid_idle", bus.f_rvalid, 1'b0);
                check("rdata_hold", bus.f_rdata, last_data);
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) != 0) a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        else                           a = $urandom;
        return a;
    endfunction

    initial begin
        int w;
        int got [10];
        int rr_exp [6] = '{1, 2, 1, 2, 1, 2};
        int st_exp [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        logic fr, lr, lm, rn;
        logic [31:0] fa, la, lw;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = ram_init(i);
        bus.f_req = 1'b0; bus.f_addr = '0; bus.l_req = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;

        // Reset held with both sides requesting
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, 32'h104, 1, 32'h20, 32'h11);
            checkOutput(w);
        end

        // Fetch only, then return of RAM[0x41]
        applyStimulus(1, 0, 1, 32'h0000_0104, 0, 0, 0);
        checkOutput(w);
        check("t2_mem_addr", bus.mem_addr, 8'h41);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput(w);
        check("t2_rdata", bus.f_rdata, ram_init(8'h41));

        // Round-robin after reset: fetch wins the first tie
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput(w);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, 32'h80 + 4 * i, 1, 32'hC0 + 4 * i, $urandom);
            checkOutput(w);
            got[i] = w;
        end
        for (int i = 0; i < 6; i++) check("rr_seq", got[i], rr_exp[i]);

        // Loader priority bounded by the starvation limit
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput(w);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 1, 32'h44, 1, 32'hE0 + 4 * i, $urandom);
            checkOutput(w);
            got[i] = w;
        end
        for (int i = 0; i < 10; i++) check("starve_seq", got[i], st_exp[i]);

        // Write then read the same word on consecutive cycles
        applyStimulus(1, 0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF);
        checkOutput(w);
        applyStimulus(1, 0, 1, 32'h10, 0, 0, 0);
        checkOutput(w);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput(w);
        check("wr_rd_data", bus.f_rdata, 32'hDEAD_BEEF);

        // Address wrap, then reset right after the fetch grant drops the return
        applyStimulus(1, 0, 1, 32'h0000_0400, 0, 0, 0);
        checkOutput(w);
        check("wrap_addr", bus.mem_addr, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput(w);
        check("rst_drop_rvalid", bus.f_rvalid, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput(w);

        // Randomized traffic with held requests, mode changes and occasional resets
        fr = 0; lr = 0; lm = 0; fa = '0; la = '0; lw = '0;
        for (int c = 0; c < 3000; c++) begin
            rn = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) lm = ~lm;
            if (!fr && $urandom_range(0, 2) != 0) begin fr = 1; fa = rand_addr(); end
            if (!lr && $urandom_range(0, 2) != 0) begin lr = 1; la = rand_addr(); lw = $urandom; end
            applyStimulus(rn, lm, fr, fa, lr, la, lw);
            checkOutput(w);
            if (w == 1) fr = 0;
            if (w == 2) lr = 0;
        end

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput(w);
        @(posedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
